// File: rtl/mux4to1_arbiter.sv
// mux4to1_arbiter: round-robin arbiter/sequencer for the shared 4:1 mux with settle window and bounded hold.
// Optional MUX_ARB_LOCK_EN adds a lock input that suspends the hold limit while the winner keeps requesting.
module mux4to1_arbiter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 8
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;
    state_t     r_state;
    logic [1:0] r_last;
    logic [1:0] r_sel;
    logic [3:0] r_gnt;
    logic [3:0] r_settle;
    logic [7:0] r_hold;
    logic       r_valid;
    logic       r_busy;
    logic [1:0] w_pick_idle;
    logic [1:0] w_pick_exit;
    logic       w_any;
    logic       w_req_win;
    logic       w_hold_max;
    logic       w_lock;
    logic       w_exit;
    // first asserted request scanning upward from last+1; last itself has lowest priority
    function automatic logic [1:0] pick(input logic [3:0] rq, input logic [1:0] last);
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (rq[idx]) pick = idx;
        end
    endfunction
`ifdef MUX_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif
    assign w_pick_idle = pick(req, r_last);
    assign w_pick_exit = pick(req, r_sel);
    assign w_any       = |req;
    assign w_req_win   = req[r_sel];
    assign w_hold_max  = r_hold == 8'(MAX_HOLD);
    assign w_exit      = !w_req_win || (w_hold_max && !w_lock);
    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;
    assign busy  = r_busy;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last   <= 2'd3;
            r_sel    <= 2'd0;
            r_gnt    <= 4'd0;
            r_settle <= 4'd0;
            r_hold   <= 8'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= SETTLE;
                        r_gnt    <= 4'b0001 << w_pick_idle;
                        r_sel    <= w_pick_idle;
                        r_settle <= 4'(SETTLE_CYCLES - 1);
                        r_busy   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!w_req_win) begin
                        r_state <= IDLE;
                        r_gnt   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else if (r_settle == 4'd0) begin
                        r_state <= GRANT;
                        r_valid <= 1'b1;
                        r_hold  <= 8'd1;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_valid <= 1'b0;
                        r_last  <= r_sel;
                        // pending requests re-arbitrate immediately without an IDLE cycle
                        if (w_any) begin
                            r_state  <= SETTLE;
                            r_gnt    <= 4'b0001 << w_pick_exit;
                            r_sel    <= w_pick_exit;
                            r_settle <= 4'(SETTLE_CYCLES - 1);
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 4'd0;
                            r_busy  <= 1'b0;
                        end
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 4'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux4to1_arbiter.sv
// tb_mux4to1_arbiter: directed checks of grant order, settle/hold timing, abort and async reset.
module tb_mux4to1_arbiter;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'd0;
`ifdef MUX_ARB_LOCK_EN
    logic       lock  = 1'b0;
`endif
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
    int vecs = 0;
    int errs = 0;
    mux4to1_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(8)) dut (
        .clk(clk),
        .reset(reset),
`ifdef MUX_ARB_LOCK_EN
        .lock(lock),
`endif
        .req(req),
        .gnt(gnt),
        .sel(sel),
        .valid(valid),
        .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic eb);
        vecs++;
        assert ({gnt, sel, valid, busy} === {eg, es, ev, eb}) else begin
            errs++;
            $error("FAIL %s: gnt/sel/valid/busy=%b/%b/%b/%b expected %b/%b/%b/%b",
                   tag, gnt, sel, valid, busy, eg, es, ev, eb);
        end
    endtask
    initial begin
        tick;
        tick;
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req = 4'b0001;
        tick;
        chk("t1_gnt", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick;
        chk("t1_settle", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick;
        chk("t1_valid", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        tick;
        chk("t1_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick;
            chk("rr_gnt", 4'b0001 << (g % 4), 2'(g % 4), 1'b0, 1'b1);
            tick;
            chk("rr_settle", 4'b0001 << (g % 4), 2'(g % 4), 1'b0, 1'b1);
            for (int v = 0; v < 8; v++) begin
                tick;
                chk("rr_hold", 4'b0001 << (g % 4), 2'(g % 4), 1'b1, 1'b1);
            end
        end
        req = 4'b0010;
        tick;
        chk("t3_gnt", 4'b0010, 2'd1, 1'b0, 1'b1);
        tick;
        chk("t3_settle", 4'b0010, 2'd1, 1'b0, 1'b1);
        for (int v = 0; v < 3; v++) begin
            tick;
            chk("t3_valid", 4'b0010, 2'd1, 1'b1, 1'b1);
        end
        req = 4'b0000;
        tick;
        chk("t3_drop", 4'b0000, 2'd1, 1'b0, 1'b0);
        req = 4'b0011;
        tick;
        chk("t3_ptr", 4'b0001, 2'd0, 1'b0, 1'b1);
        req = 4'b0000;
        tick;
        chk("abort", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0110;
        tick;
        chk("abort_ptr", 4'b0100, 2'd2, 1'b0, 1'b1);
        req = 4'b0100;
        for (int k = 1; k <= 25; k++) begin
            tick;
            chk("t4_sole", 4'b0100, 2'd2, (k % 10) >= 2, 1'b1);
        end
        reset = 1'b1;
        #1;
        chk("t5_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req = 4'b1000;
        tick;
        chk("t5_gnt", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick;
        chk("t5_settle", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick;
        chk("t5_valid", 4'b1000, 2'd3, 1'b1, 1'b1);
        req = 4'b0000;
        tick;
        chk("t5_drop", 4'b0000, 2'd3, 1'b0, 1'b0);
`ifdef MUX_ARB_LOCK_EN
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 4'b1001;
        lock = 1'b1;
        tick;
        chk("t6_gnt", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick;
        chk("t6_settle", 4'b0001, 2'd0, 1'b0, 1'b1);
        for (int v = 0; v < 20; v++) begin
            tick;
            chk("t6_lock", 4'b0001, 2'd0, 1'b1, 1'b1);
        end
        lock = 1'b0;
        tick;
        chk("t6_exit", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick;
        chk("t6_settle2", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick;
        chk("t6_valid2", 4'b1000, 2'd3, 1'b1, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
